// File: rtl/irq_arbiter_10.sv
// 10-source interrupt request controller: qualifies, latches, masks and prioritises requests for the core.
// Optional build macro IRQ_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module irq_arbiter_10 #(
  parameter logic [9:0] BubblesMask = 10'h000,
  parameter logic [9:0] EdgeMask    = 10'h000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] Irq_In,
  input  logic [9:0] Mask_In,
  input  logic       Ack,
  input  logic       Eret,
  output logic       Irq_Req,
  output logic [3:0] Irq_Id,
  output logic       In_Service,
  output logic [9:0] Pending,
  output logic       Any_Pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state_q, state_d;
  logic [9:0] active_w, prev_q, rise_w, clr_w, eligible_w;
  logic [9:0] pend_q, pend_d;
  logic [3:0] id_q, id_d, winner_w;
  logic       grant_w;

  always_comb begin
    active_w   = Irq_In ^ BubblesMask;
    rise_w     = active_w & ~prev_q;
    eligible_w = pend_q & Mask_In;
    grant_w    = (state_q == REQ) && Ack;
  end

  // Only the granted edge source is cleared; a new rise in the same cycle still sets it.
  always_comb begin
    clr_w = '0;
    for (int i = 0; i < 10; i++) begin
      clr_w[i] = grant_w && (id_q == 4'(i)) && EdgeMask[i];
    end
    pend_d = (EdgeMask & (rise_w | (pend_q & ~clr_w))) | (~EdgeMask & active_w);
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0] ptr_q;

  // Search starts just after the last granted source and wraps 9 -> 0.
  always_comb begin
    int   idx;
    logic found;
    winner_w = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= 10; k++) begin
      idx = (int'(ptr_q) + k) % 10;
      if (!found && eligible_w[idx]) begin
        winner_w = 4'(idx);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_q <= 4'd9;
    end else if (grant_w) begin
      ptr_q <= id_q;
    end
  end
`else
  always_comb begin
    winner_w = '0;
    for (int i = 9; i >= 0; i--) begin
      if (eligible_w[i]) begin
        winner_w = 4'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (Any_Pending) begin
          state_d = REQ;
          id_d    = winner_w;
        end
      end
      REQ: begin
        if (Ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (Eret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // prev_q resets low so a source already active at reset release counts as a rise.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= active_w;
      pend_q  <= pend_d;
      id_q    <= id_d;
    end
  end

  assign Irq_Req     = (state_q == REQ);
  assign In_Service  = (state_q == SERVICE);
  assign Irq_Id      = id_q;
  assign Pending     = pend_q;
  assign Any_Pending = |(pend_q & Mask_In);

endmodule

// File: tb/tb_irq_arbiter_10.sv
// Directed bench for irq_arbiter_10: one edge/level mixed instance and one active-low level instance.
module tb_irq_arbiter_10;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [9:0] IrqA, MaskA, IrqB, MaskB;
  logic       AckA, EretA, AckB, EretB;
  logic       ReqA, InSvcA, AnyA, ReqB, InSvcB, AnyB;
  logic [3:0] IdA, IdB;
  logic [9:0] PendA, PendB;
  int         nChecks = 0;
  int         nFails = 0;

  // Instance A: every source edge-triggered except source index 5, which is level.
  irq_arbiter_10 #(.BubblesMask(10'h000), .EdgeMask(10'h3DF)) dutA (
    .Clock(Clock), .Reset(Reset), .Irq_In(IrqA), .Mask_In(MaskA),
    .Ack(AckA), .Eret(EretA), .Irq_Req(ReqA), .Irq_Id(IdA),
    .In_Service(InSvcA), .Pending(PendA), .Any_Pending(AnyA));

  // Instance B: all level sources, index 0 active-low.
  irq_arbiter_10 #(.BubblesMask(10'h001), .EdgeMask(10'h000)) dutB (
    .Clock(Clock), .Reset(Reset), .Irq_In(IrqB), .Mask_In(MaskB),
    .Ack(AckB), .Eret(EretB), .Irq_Req(ReqB), .Irq_Id(IdB),
    .In_Service(InSvcB), .Pending(PendB), .Any_Pending(AnyB));

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (5) tick();
    nChecks++; if (ReqA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_req: got %0b want 0", ReqA); end
    nChecks++; if (PendA !== 10'h000) begin nFails++; $display("[TB] FAIL reset_pend: got %h want 000", PendA); end
    nChecks++; if (AnyA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_any: got %0b want 0", AnyA); end
    nChecks++; if (IdA !== 4'd0) begin nFails++; $display("[TB] FAIL reset_id: got %0d want 0", IdA); end
  endtask

  task automatic test_edge;
    IrqA = 10'h008;
    tick();
    IrqA = 10'h000;
    nChecks++; if (PendA !== 10'h008) begin nFails++; $display("[TB] FAIL edge_pend: got %h want 008", PendA); end
    nChecks++; if (ReqA !== 1'b0) begin nFails++; $display("[TB] FAIL edge_req_early: got %0b want 0", ReqA); end
    tick();
    nChecks++; if (ReqA !== 1'b1) begin nFails++; $display("[TB] FAIL edge_req: got %0b want 1", ReqA); end
    nChecks++; if (IdA !== 4'd3) begin nFails++; $display("[TB] FAIL edge_id: got %0d want 3", IdA); end
    AckA = 1'b1;
    tick();
    AckA = 1'b0;
    nChecks++; if (PendA !== 10'h000) begin nFails++; $display("[TB] FAIL edge_ack_pend: got %h want 000", PendA); end
    nChecks++; if (InSvcA !== 1'b1) begin nFails++; $display("[TB] FAIL edge_insvc: got %0b want 1", InSvcA); end
    nChecks++; if (ReqA !== 1'b0) begin nFails++; $display("[TB] FAIL edge_ack_req: got %0b want 0", ReqA); end
    EretA = 1'b1;
    tick();
    EretA = 1'b0;
    nChecks++; if (InSvcA !== 1'b0) begin nFails++; $display("[TB] FAIL edge_eret_insvc: got %0b want 0", InSvcA); end
    tick();
    nChecks++; if (ReqA !== 1'b0) begin nFails++; $display("[TB] FAIL edge_idle_req: got %0b want 0", ReqA); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] first, second;
    logic [9:0] leftPend;
`ifdef IRQ_ROUND_ROBIN_EN
    first = 4'd7; second = 4'd2; leftPend = 10'h004;
`else
    first = 4'd2; second = 4'd7; leftPend = 10'h080;
`endif
    IrqA = 10'h084;
    tick();
    IrqA = 10'h000;
    nChecks++; if (PendA !== 10'h084) begin nFails++; $display("[TB] FAIL b2b_pend: got %h want 084", PendA); end
    tick();
    nChecks++; if (IdA !== first || ReqA !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_first: got id %0d req %0b want id %0d req 1", IdA, ReqA, first); end
    AckA = 1'b1;
    tick();
    AckA = 1'b0;
    nChecks++; if (PendA !== leftPend) begin nFails++; $display("[TB] FAIL b2b_left: got %h want %h", PendA, leftPend); end
    EretA = 1'b1;
    tick();
    EretA = 1'b0;
    nChecks++; if (ReqA !== 1'b0 || InSvcA !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_gap: got req %0b insvc %0b want 0 0", ReqA, InSvcA); end
    tick();
    nChecks++; if (IdA !== second || ReqA !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_second: got id %0d req %0b want id %0d req 1", IdA, ReqA, second); end
    AckA = 1'b1;
    tick();
    AckA = 1'b0;
    EretA = 1'b1;
    tick();
    EretA = 1'b0;
    nChecks++; if (PendA !== 10'h000) begin nFails++; $display("[TB] FAIL b2b_clear: got %h want 000", PendA); end
  endtask

  task automatic test_level_mask;
    MaskA = 10'h3DF;
    IrqA  = 10'h020;
    tick();
    nChecks++; if (PendA !== 10'h020) begin nFails++; $display("[TB] FAIL lvl_pend: got %h want 020", PendA); end
    nChecks++; if (AnyA !== 1'b0) begin nFails++; $display("[TB] FAIL lvl_any_masked: got %0b want 0", AnyA); end
    tick();
    nChecks++; if (ReqA !== 1'b0) begin nFails++; $display("[TB] FAIL lvl_no_req: got %0b want 0", ReqA); end
    MaskA = 10'h3FF;
    #1;
    nChecks++; if (AnyA !== 1'b1) begin nFails++; $display("[TB] FAIL lvl_any: got %0b want 1", AnyA); end
    tick();
    nChecks++; if (ReqA !== 1'b1 || IdA !== 4'd5) begin nFails++; $display("[TB] FAIL lvl_req: got req %0b id %0d want 1 5", ReqA, IdA); end
    AckA = 1'b1;
    tick();
    AckA = 1'b0;
    nChecks++; if (PendA !== 10'h020) begin nFails++; $display("[TB] FAIL lvl_ack_pend: got %h want 020", PendA); end
    IrqA  = 10'h000;
    MaskA = 10'h3DF;
    tick();
    EretA = 1'b1;
    tick();
    EretA = 1'b0;
    tick();
    nChecks++; if (ReqA !== 1'b0 || PendA !== 10'h000) begin nFails++; $display("[TB] FAIL lvl_end: got req %0b pend %h want 0 000", ReqA, PendA); end
    MaskA = 10'h3FF;
  endtask

  task automatic test_mask_drop_reset;
    IrqA = 10'h010;
    tick();
    IrqA = 10'h000;
    tick();
    nChecks++; if (ReqA !== 1'b1 || IdA !== 4'd4) begin nFails++; $display("[TB] FAIL drop_req: got req %0b id %0d want 1 4", ReqA, IdA); end
    MaskA = 10'h3EF;
    repeat (2) tick();
    nChecks++; if (ReqA !== 1'b1 || IdA !== 4'd4) begin nFails++; $display("[TB] FAIL drop_hold: got req %0b id %0d want 1 4", ReqA, IdA); end
    AckA = 1'b1;
    tick();
    AckA = 1'b0;
    nChecks++; if (InSvcA !== 1'b1) begin nFails++; $display("[TB] FAIL drop_insvc: got %0b want 1", InSvcA); end
    #2;
    Reset = 1'b1;
    #1;
    nChecks++; if (ReqA !== 1'b0 || InSvcA !== 1'b0) begin nFails++; $display("[TB] FAIL async_reset: got req %0b insvc %0b want 0 0", ReqA, InSvcA); end
    tick();
    Reset = 1'b0;
    MaskA = 10'h3FF;
    repeat (3) tick();
    nChecks++; if (ReqA !== 1'b0 || PendA !== 10'h000) begin nFails++; $display("[TB] FAIL no_replay: got req %0b pend %h want 0 000", ReqA, PendA); end
  endtask

  task automatic test_round_robin;
    logic [3:0] expId [4];
`ifdef IRQ_ROUND_ROBIN_EN
    expId = '{4'd0, 4'd1, 4'd0, 4'd1};
`else
    expId = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    IrqB  = 10'h002;
    MaskB = 10'h3FF;
    tick();
    nChecks++; if (PendB !== 10'h003) begin nFails++; $display("[TB] FAIL rr_pend: got %h want 003", PendB); end
    for (int g = 0; g < 4; g++) begin
      int w = 0;
      while (ReqB !== 1'b1 && w < 6) begin
        tick();
        w++;
      end
      nChecks++; if (ReqB !== 1'b1) begin nFails++; $display("[TB] FAIL rr_timeout: grant %0d got req %0b want 1", g, ReqB); end
      nChecks++; if (IdB !== expId[g]) begin nFails++; $display("[TB] FAIL rr_id: grant %0d got %0d want %0d", g, IdB, expId[g]); end
      AckB = 1'b1;
      tick();
      AckB = 1'b0;
      EretB = 1'b1;
      tick();
      EretB = 1'b0;
    end
  endtask

  initial begin
    Reset = 1'b1;
    IrqA = '0; MaskA = 10'h3FF; AckA = 1'b0; EretA = 1'b0;
    IrqB = '0; MaskB = 10'h000; AckB = 1'b0; EretB = 1'b0;
    test_reset();
    test_edge();
    test_back_to_back();
    test_level_mask();
    test_mask_drop_reset();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/irq_arbiter_10.md
Name: irq_arbiter_10

Overview:
- Sequential 10-source interrupt request controller for the single-cycle RISC-V core.
- Qualifies, latches, masks and prioritises 10 request lines, then presents one winner to the core.
- Uses a request/acknowledge/return handshake.
- Its "any pending" output replaces a bare 10-input OR reduction of the request lines.

Parameters:
- BubblesMask, 0, 10-bit per-source input inversion; bit i set means source i is active-low.
- EdgeMask, 0, 10-bit per-source trigger type; bit i set means rising-edge triggered, clear means level triggered.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Irq_In  input  10  raw request lines; bit 0 is source 1 (highest priority), bit 9 is source 10.
- Mask_In  input  10  per-source enable; 1 means enabled.
- Ack  input  1  core accepts the presented request.
- Eret  input  1  core finished servicing the current interrupt.
- Irq_Req  output  1  request to core.
- Irq_Id  output  4  winning source index, 0..9.
- In_Service  output  1  core is servicing an interrupt.
- Pending  output  10  registered pending bits.
- Any_Pending  output  1  OR of (Pending & Mask_In), combinational.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - Pending, edge sampler, Irq_Id, Irq_Req and In_Service all = 0.
  - An edge source already high when Reset releases registers as an edge on the first clock.
- Real input: r[i] = Irq_In[i] XOR BubblesMask[i].
- Edge source: Pending[i] sets on a rising Clock edge where r[i]=1 and the sampled previous r[i]=0. It clears only when granted (Ack accepted for that id).
- Level source: Pending[i] = registered r[i]. It is never cleared by Ack.
- Set and clear of the same edge bit in one cycle: set wins.
- Mask does not affect Pending. Mask only gates arbitration and Any_Pending.
- Arbitration: lowest index among Pending & Mask_In wins (fixed priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if Any_Pending, go to REQ next edge, load Irq_Id = winner, assert Irq_Req.
  - REQ: Irq_Req=1 and Irq_Id held stable. The request is committed even if the source becomes masked or its level drops. On Ack go to SERVICE: Irq_Req=0, In_Service=1, clear Pending[Irq_Id] if it is an edge source.
  - SERVICE: Irq_Id held. Higher-priority arrivals stay pending. On Eret go to IDLE, In_Service=0.
- Latency: input rise at edge k → Pending visible after edge k → Irq_Req high after edge k+1, i.e. 2 cycles.
- Back-to-back: with another source pending at Eret, the FSM re-enters REQ one cycle after IDLE. There is a minimum 1-cycle IDLE gap.
- Ignored inputs:
  - Ack in IDLE or SERVICE.
  - Eret in IDLE or REQ.
  - Ack and Eret together in SERVICE: handled as Eret only.
- Reset mid-operation: all state is dropped. No request is replayed except through a live level or a new edge.

Optional Feature:
- Macro IRQ_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin.
  - A 4-bit last-grant pointer updates on each Ack.
  - The search starts at last_grant+1 and wraps 9→0.
  - The pointer resets to 9, so the first search starts at 0.
- Undefined: fixed lowest-index priority, and no pointer register is generated.

Test Plan:
- Reset release, Irq_In=0, Mask_In=3FF → after 5 cycles Irq_Req=0, Pending=000, Any_Pending=0, Irq_Id=0.
- EdgeMask=3FF. Pulse Irq_In[3] for 1 cycle → Pending=008 next cycle, Irq_Req=1 with Irq_Id=3 two cycles after the rise. Ack → Pending=000, In_Service=1. Eret → IDLE, Irq_Req stays 0.
- Pending bits 2 and 7 together, fixed priority → grant 2. After Eret, re-request with Irq_Id=7 after a 1-cycle IDLE gap.
- Level source 5 held high, Mask_In[5]=0 → Pending[5]=1, Any_Pending=0, no request. Set Mask_In[5]=1 → Irq_Req with Irq_Id=5. Ack leaves Pending[5]=1.
- In REQ with Irq_Id=4, drop Mask_In[4] → Irq_Req stays 1 with Irq_Id=4 until Ack. Assert Reset in SERVICE → Irq_Req=0 and In_Service=0 immediately, without waiting for a clock edge.
- IRQ_ROUND_ROBIN_EN defined, BubblesMask=001, Irq_In[0]=0 held, sources 0 and 1 level-pending continuously → grants alternate 0,1,0,1 across successive Ack/Eret cycles.
